writeback_arbiter: RTL and testbench

//  Shares the single common data bus (CDB / PRF write port) between the ALU, load and branch

---
 rtl/writeback_arbiter_pkg.sv | 19 +
 rtl/writeback_arbiter_wb_fifo.sv | 57 +++++
 rtl/writeback_arbiter.sv | 84 ++++++++
 tb/tb_writeback_arbiter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/writeback_arbiter_pkg.sv
// writeback_arbiter_pkg: source ids, default entry layout and round-robin helper for the writeback arbiter.
package writeback_arbiter_pkg;
  localparam int NUM_WB_SRC = 3;
  localparam int WB_ROB_W = 5;
  localparam int WB_PHY_W = 6;
  localparam int WB_DATA_W = 32;
  typedef enum logic [1:0] {SRC_ALU = 2'd0, SRC_LS = 2'd1, SRC_BR = 2'd2} WB_SRC_t;
  typedef struct packed {
    logic [WB_ROB_W-1:0]  rob_id;
    logic [WB_PHY_W-1:0]  rd_phy;
    logic [WB_DATA_W-1:0] data;
  } WB_ENTRY_t;
  function automatic WB_SRC_t src_next(input WB_SRC_t s, input logic [1:0] k);
    logic [2:0] t;
    t = {1'b0, s} + {1'b0, k};
    t = (t >= 3'd3) ? t - 3'd3 : t;
    return WB_SRC_t'(t[1:0]);
  endfunction
endpackage

// File: rtl/writeback_arbiter_wb_fifo.sv
// wb_fifo: per-source result FIFO with registered count and age-based tail truncation on flush.
module wb_fifo #(
  parameter int W = 43,
  parameter int ROB_WIDTH = 5,
  parameter int DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic                 pop,
  input  logic                 flush,
  input  logic [W-1:0]         push_entry,
  input  logic [ROB_WIDTH-1:0] rob_head,
  input  logic [ROB_WIDTH-1:0] flush_rob_id,
  output logic [W-1:0]         head,
  output logic                 empty,
  output logic                 ready
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_idx;
  logic [CW-1:0] count, keep;
  logic do_push, push_keep, wr_en;
  function automatic logic [ROB_WIDTH-1:0] age(input logic [ROB_WIDTH-1:0] id);
    return id - rob_head;
  endfunction
  function automatic logic survives(input logic [W-1:0] e);
    return age(e[W-1 -: ROB_WIDTH]) <= age(flush_rob_id);
  endfunction
  assign ready = count < CW'(DEPTH);
  assign empty = count == '0;
  assign head = mem[rd_ptr];
  assign do_push = push && ready;
  assign push_keep = do_push && survives(push_entry);
  // Entries are age-ordered, so survivors form a contiguous run from the head.
  always_comb begin
    keep = '0;
    for (int i = 0; i < DEPTH; i++)
      if (CW'(i) == keep && CW'(i) < count && survives(mem[rd_ptr + AW'(i)])) keep = keep + 1'b1;
  end
  assign wr_en = flush ? push_keep : do_push;
  assign wr_idx = rd_ptr + (flush ? AW'(keep) : AW'(count));
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rd_ptr <= '0;
      count <= '0;
    end else if (flush) begin
      count <= keep + CW'(push_keep);
    end else begin
      rd_ptr <= rd_ptr + AW'(pop);
      count <= count + CW'(do_push) - CW'(pop);
    end
  always_ff @(posedge clk)
    if (wr_en) mem[wr_idx] <= push_entry;
  assert property (@(posedge clk) disable iff (rst) push |-> ready);
endmodule

// File: rtl/writeback_arbiter.sv
// writeback_arbiter: shares the CDB between ALU, load and branch pipes with per-source FIFOs and flush squash.
// WB_ARB_RR_EN selects round-robin arbitration; otherwise fixed priority BR > LS > ALU.
module writeback_arbiter
  import writeback_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ROB_WIDTH = 5,
  parameter int PHY_WIDTH = 6,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alu_wb_valid,
  input  logic [ROB_WIDTH-1:0]  alu_wb_rob_id,
  input  logic [PHY_WIDTH-1:0]  alu_wb_rd_phy,
  input  logic [DATA_WIDTH-1:0] alu_wb_data,
  output logic                  alu_wb_ready,
  input  logic                  ls_wb_valid,
  input  logic [ROB_WIDTH-1:0]  ls_wb_rob_id,
  input  logic [PHY_WIDTH-1:0]  ls_wb_rd_phy,
  input  logic [DATA_WIDTH-1:0] ls_wb_data,
  output logic                  ls_wb_ready,
  input  logic                  br_wb_valid,
  input  logic [ROB_WIDTH-1:0]  br_wb_rob_id,
  input  logic [PHY_WIDTH-1:0]  br_wb_rd_phy,
  input  logic [DATA_WIDTH-1:0] br_wb_data,
  output logic                  br_wb_ready,
  input  logic [ROB_WIDTH-1:0]  rob_head,
  input  logic                  flush,
  input  logic [ROB_WIDTH-1:0]  flush_rob_id,
  output logic                  cdb_valid,
  output logic [ROB_WIDTH-1:0]  cdb_rob_id,
  output logic [PHY_WIDTH-1:0]  cdb_rd_phy,
  output logic [DATA_WIDTH-1:0] cdb_data,
  output WB_SRC_t               cdb_src
);
  localparam int EW = ROB_WIDTH + PHY_WIDTH + DATA_WIDTH;
  logic [EW-1:0] in_e [NUM_WB_SRC];
  logic [EW-1:0] head_e [NUM_WB_SRC];
  logic [NUM_WB_SRC-1:0] in_v, pop, empty, rdy;
  logic grant;
  WB_SRC_t gnt;
  assign in_v = {br_wb_valid, ls_wb_valid, alu_wb_valid};
  assign in_e[0] = {alu_wb_rob_id, alu_wb_rd_phy, alu_wb_data};
  assign in_e[1] = {ls_wb_rob_id, ls_wb_rd_phy, ls_wb_data};
  assign in_e[2] = {br_wb_rob_id, br_wb_rd_phy, br_wb_data};
  assign {br_wb_ready, ls_wb_ready, alu_wb_ready} = rdy;
  for (genvar g = 0; g < NUM_WB_SRC; g++) begin : g_fifo
    wb_fifo #(.W(EW), .ROB_WIDTH(ROB_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk, .rst, .push(in_v[g]), .pop(pop[g]), .flush, .push_entry(in_e[g]),
      .rob_head, .flush_rob_id, .head(head_e[g]), .empty(empty[g]), .ready(rdy[g])
    );
  end
`ifdef WB_ARB_RR_EN
  WB_SRC_t rr_ptr;
  // Scan from the far end so the first non-empty source after rr_ptr wins.
  always_comb begin
    gnt = SRC_ALU;
    for (int k = NUM_WB_SRC - 1; k >= 0; k--)
      if (!empty[src_next(rr_ptr, 2'(k))]) gnt = src_next(rr_ptr, 2'(k));
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) rr_ptr <= SRC_ALU;
    else if (grant) rr_ptr <= src_next(gnt, 2'd1);
`else
  assign gnt = !empty[SRC_BR] ? SRC_BR : !empty[SRC_LS] ? SRC_LS : SRC_ALU;
`endif
  assign grant = !(&empty) && !flush;
  assign pop = grant ? NUM_WB_SRC'(1) << gnt : '0;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cdb_valid <= 1'b0;
      cdb_rob_id <= '0;
      cdb_rd_phy <= '0;
      cdb_data <= '0;
      cdb_src <= SRC_ALU;
    end else begin
      cdb_valid <= grant;
      if (grant) begin
        {cdb_rob_id, cdb_rd_phy, cdb_data} <= head_e[gnt];
        cdb_src <= gnt;
      end
    end
endmodule

// File: tb/tb_writeback_arbiter.sv
// tb_writeback_arbiter: randomized queue-model bench plus directed literal checks for writeback_arbiter.
module tb_writeback_arbiter;
  import writeback_arbiter_pkg::*;
  logic clk, rst;
  logic alu_wb_valid, ls_wb_valid, br_wb_valid;
  logic [4:0] alu_wb_rob_id, ls_wb_rob_id, br_wb_rob_id;
  logic [5:0] alu_wb_rd_phy, ls_wb_rd_phy, br_wb_rd_phy;
  logic [31:0] alu_wb_data, ls_wb_data, br_wb_data;
  logic alu_wb_ready, ls_wb_ready, br_wb_ready;
  logic [4:0] rob_head, flush_rob_id;
  logic flush;
  logic cdb_valid;
  logic [4:0] cdb_rob_id;
  logic [5:0] cdb_rd_phy;
  logic [31:0] cdb_data;
  WB_SRC_t cdb_src;

  writeback_arbiter dut (
    .clk(clk), .rst(rst),
    .alu_wb_valid(alu_wb_valid), .alu_wb_rob_id(alu_wb_rob_id), .alu_wb_rd_phy(alu_wb_rd_phy),
    .alu_wb_data(alu_wb_data), .alu_wb_ready(alu_wb_ready),
    .ls_wb_valid(ls_wb_valid), .ls_wb_rob_id(ls_wb_rob_id), .ls_wb_rd_phy(ls_wb_rd_phy),
    .ls_wb_data(ls_wb_data), .ls_wb_ready(ls_wb_ready),
    .br_wb_valid(br_wb_valid), .br_wb_rob_id(br_wb_rob_id), .br_wb_rd_phy(br_wb_rd_phy),
    .br_wb_data(br_wb_data), .br_wb_ready(br_wb_ready),
    .rob_head(rob_head), .flush(flush), .flush_rob_id(flush_rob_id),
    .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_rd_phy(cdb_rd_phy),
    .cdb_data(cdb_data), .cdb_src(cdb_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rob;
    logic [5:0]  phy;
    logic [31:0] data;
  } ent_t;

  ent_t q[3][$];
  logic e_valid;
  logic [4:0] e_rob;
  logic [5:0] e_phy;
  logic [31:0] e_data;
  int e_src, rr;
  int checks = 0, failures = 0;
  bit chk_en = 0;

  function automatic int age(logic [4:0] id);
    return (int'(id) - int'(rob_head) + 32) % 32;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: one queue per source, updated at every active edge.
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      for (int s = 0; s < 3; s++) q[s].delete();
      e_valid = 0; e_rob = 0; e_phy = 0; e_data = 0; e_src = 0; rr = 0;
    end else begin
      ent_t nw[3];
      ent_t kept[$];
      bit pv[3];
      int w, fa;
      pv[0] = alu_wb_valid && q[0].size() < 2;
      pv[1] = ls_wb_valid && q[1].size() < 2;
      pv[2] = br_wb_valid && q[2].size() < 2;
      nw[0] = '{alu_wb_rob_id, alu_wb_rd_phy, alu_wb_data};
      nw[1] = '{ls_wb_rob_id, ls_wb_rd_phy, ls_wb_data};
      nw[2] = '{br_wb_rob_id, br_wb_rd_phy, br_wb_data};
      if (flush) begin
        fa = age(flush_rob_id);
        for (int s = 0; s < 3; s++) begin
          kept.delete();
          foreach (q[s][j]) if (age(q[s][j].rob) <= fa) kept.push_back(q[s][j]);
          q[s] = kept;
          if (pv[s] && age(nw[s].rob) <= fa) q[s].push_back(nw[s]);
        end
        e_valid = 0;
      end else begin
        w = -1;
`ifdef WB_ARB_RR_EN
        for (int k = 0; k < 3; k++) if (w < 0 && q[(rr + k) % 3].size() > 0) w = (rr + k) % 3;
`else
        for (int s = 0; s < 3; s++) if (q[s].size() > 0) w = s;
`endif
        e_valid = (w >= 0);
        if (w >= 0) begin
          ent_t h;
          h = q[w].pop_front();
          e_rob = h.rob; e_phy = h.phy; e_data = h.data; e_src = w;
          rr = (w + 1) % 3;
        end
        for (int s = 0; s < 3; s++) if (pv[s]) q[s].push_back(nw[s]);
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (!rst && chk_en) begin
      check("cdb_valid", 32'(cdb_valid), 32'(e_valid));
      check("cdb_rob_id", 32'(cdb_rob_id), 32'(e_rob));
      check("cdb_rd_phy", 32'(cdb_rd_phy), 32'(e_phy));
      check("cdb_data", cdb_data, e_data);
      check("cdb_src", 32'(cdb_src), 32'(e_src));
      check("alu_wb_ready", 32'(alu_wb_ready), 32'(q[0].size() < 2));
      check("ls_wb_ready", 32'(ls_wb_ready), 32'(q[1].size() < 2));
      check("br_wb_ready", 32'(br_wb_ready), 32'(q[2].size() < 2));
    end
  end

  task automatic idle();
    alu_wb_valid = 0; ls_wb_valid = 0; br_wb_valid = 0; flush = 0;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_src(int s, logic v, logic [4:0] r, logic [5:0] p, logic [31:0] d);
    case (s)
      0: begin alu_wb_valid = v; alu_wb_rob_id = r; alu_wb_rd_phy = p; alu_wb_data = d; end
      1: begin ls_wb_valid = v; ls_wb_rob_id = r; ls_wb_rd_phy = p; ls_wb_data = d; end
      default: begin br_wb_valid = v; br_wb_rob_id = r; br_wb_rd_phy = p; br_wb_data = d; end
    endcase
  endtask

  task automatic do_reset();
    rst = 1;
    idle();
    tick();
    tick();
    rst = 0;
  endtask

  initial begin
    logic [4:0] nxt, span;
    int pct;
    rst = 1; idle(); rob_head = 0; flush_rob_id = 0;
    for (int s = 0; s < 3; s++) set_src(s, 0, 0, 0, 0);
    tick();
    check("rst_cdb_valid", 32'(cdb_valid), 0);
    check("rst_cdb_src", 32'(cdb_src), 32'(SRC_ALU));
    check("rst_readies", 32'({alu_wb_ready, ls_wb_ready, br_wb_ready}), 32'h7);
    tick();
    rst = 0;
    chk_en = 1;

    set_src(0, 1, 5'd3, 6'd7, 32'h55);
    tick();
    idle();
    check("t1_not_yet", 32'(cdb_valid), 0);
    tick();
    check("t1_valid", 32'(cdb_valid), 1);
    check("t1_rob", 32'(cdb_rob_id), 3);
    check("t1_phy", 32'(cdb_rd_phy), 7);
    check("t1_data", cdb_data, 32'h55);
    check("t1_src", 32'(cdb_src), 32'(SRC_ALU));
    tick();
    check("t1_pulse", 32'(cdb_valid), 0);

    rob_head = 5'd30;
    set_src(0, 1, 5'd31, 6'd3, 32'h31); flush = 1; flush_rob_id = 5'd1;
    tick();
    set_src(0, 1, 5'd1, 6'd4, 32'h01); flush = 1; flush_rob_id = 5'd1;
    tick();
    idle();
    check("t4_alu_full", 32'(alu_wb_ready), 0);
    flush = 1; flush_rob_id = 5'd0;
    tick();
    idle();
    check("t4_alu_ready", 32'(alu_wb_ready), 1);
    tick();
    check("t4_valid", 32'(cdb_valid), 1);
    check("t4_rob", 32'(cdb_rob_id), 31);
    check("t4_data", cdb_data, 32'h31);
    tick();
    check("t4_dropped", 32'(cdb_valid), 0);

    rob_head = 5'd10;
    set_src(2, 1, 5'd12, 6'd1, 32'hB); set_src(0, 1, 5'd13, 6'd2, 32'hA);
    flush = 1; flush_rob_id = 5'd12;
    tick();
    idle();
    check("t5_flush_edge", 32'(cdb_valid), 0);
    tick();
    check("t5_br_valid", 32'(cdb_valid), 1);
    check("t5_br_rob", 32'(cdb_rob_id), 12);
    check("t5_br_src", 32'(cdb_src), 32'(SRC_BR));
    tick();
    check("t5_alu_dropped", 32'(cdb_valid), 0);

    for (int ph = 0; ph < 60; ph++) begin
      rob_head = 5'($urandom);
      nxt = rob_head + 5'($urandom_range(0, 3));
      pct = (ph < 4) ? 100 : int'($urandom_range(20, 80));
      for (int c = 0; c < 8; c++) begin
        for (int s = 0; s < 3; s++)
          if (int'($urandom % 100) < pct && q[s].size() < 2) begin
            set_src(s, 1, nxt, 6'($urandom), $urandom);
            nxt = nxt + 5'd1;
          end else set_src(s, 0, 0, 0, 0);
        flush = (c >= 2 && $urandom % 6 == 0);
        span = nxt - rob_head;
        flush_rob_id = rob_head + 5'($urandom_range(0, int'(span)));
        tick();
      end
      idle();
      repeat (6) tick();
    end

    rob_head = 0;
    for (int c = 0; c < 2; c++) begin
      for (int s = 0; s < 3; s++) set_src(s, 1, 5'(1 + c * 3 + s), 6'(s), 32'(c * 16 + s));
      tick();
    end
    idle();
    check("t6_buffered", 32'(q[0].size() + q[1].size() + q[2].size()), 5);
    #2 rst = 1;
    #1;
    check("t6_cdb_valid", 32'(cdb_valid), 0);
    check("t6_cdb_rob", 32'(cdb_rob_id), 0);
    check("t6_cdb_data", cdb_data, 0);
    check("t6_readies", 32'({alu_wb_ready, ls_wb_ready, br_wb_ready}), 32'h7);
    tick();
    do_reset();
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
